// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and constants used by the issue stage and its ALU.
package alu_pkg;
  typedef logic [2:0] alu_opcode_t;

  localparam alu_opcode_t OP_ADD = 3'b000;
  localparam alu_opcode_t OP_SUB = 3'b001;
  localparam alu_opcode_t OP_AND = 3'b010;
  localparam alu_opcode_t OP_XOR = 3'b011;

  // Result the ALU returns for unassigned opcodes; callers take the low N bits.
  localparam logic [63:0] ALU_DEFAULT_RESULT = '1;
endpackage

// File: rtl/alu_cmd_issue_if.sv
// Command, ALU-drive and result signals of the ALU issue stage.
interface alu_cmd_issue_if import alu_pkg::*; #(
  parameter int N     = 8,
  parameter int DEPTH = 4
);
  logic                       in_valid;
  logic                       in_ready;
  alu_opcode_t                in_opcode;
  logic [N-1:0]               in_a;
  logic [N-1:0]               in_b;
  logic                       in_use_acc;
  alu_opcode_t                alu_opcode;
  logic [N-1:0]               alu_a;
  logic [N-1:0]               alu_b;
  logic [N-1:0]               alu_result;
  logic                       out_valid;
  logic                       out_ready;
  logic [N-1:0]               out_result;
  alu_opcode_t                out_opcode;
  logic                       out_zero;
  logic [N-1:0]               acc;
  logic [$clog2(DEPTH):0]     level;

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_use_acc, alu_result, out_ready,
    output in_ready, alu_opcode, alu_a, alu_b, out_valid, out_result, out_opcode,
           out_zero, acc, level
  );

  modport master (
    output in_valid, in_opcode, in_a, in_b, in_use_acc, alu_result, out_ready,
    input  in_ready, alu_opcode, alu_a, alu_b, out_valid, out_result, out_opcode,
           out_zero, acc, level
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with occupancy count; head entry is always visible on rdata.
module alu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          do_push, do_pop;

  assign full    = (cnt_q == LW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/alu_cmd_issue.sv
// ALU issue stage: queues commands, drives the ALU from the FIFO head, and
// registers results with a valid/ready output plus a chaining accumulator.
module alu_cmd_issue import alu_pkg::*; #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_cmd_issue_if.slave io
);
  typedef struct packed {
    alu_opcode_t  opcode;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         use_acc;
  } cmd_t;

  localparam int CW = $bits(cmd_t);

  cmd_t         wr_cmd, head;
  logic [CW-1:0] head_raw;
  logic         fifo_full, fifo_empty;
  logic         push, issue;

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_result_q, out_result_d;
  alu_opcode_t  out_opcode_q, out_opcode_d;
  logic         out_zero_q, out_zero_d;
  logic [N-1:0] acc_q, acc_d;

  assign wr_cmd = '{opcode: io.in_opcode, a: io.in_a, b: io.in_b, use_acc: io.in_use_acc};
  assign head   = cmd_t'(head_raw);

  // in_ready depends only on the registered count, never on this cycle's pop.
  assign io.in_ready = !fifo_full;
  assign push        = io.in_valid && !fifo_full;
  assign issue       = !fifo_empty && (!out_valid_q || io.out_ready);

  alu_cmd_fifo #(.W(CW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (CW'(wr_cmd)),
    .pop   (issue),
    .rdata (head_raw),
    .level (io.level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Idle ALU inputs are forced to zero so stale FIFO contents never toggle the ALU.
  always_comb begin
    io.alu_opcode = '0;
    io.alu_a      = '0;
    io.alu_b      = '0;
    if (!fifo_empty) begin
      io.alu_opcode = head.opcode;
      io.alu_a      = head.use_acc ? acc_q : head.a;
      io.alu_b      = head.b;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_opcode_d = out_opcode_q;
    out_zero_d   = out_zero_q;
    acc_d        = acc_q;
    if (issue) begin
      out_valid_d  = 1'b1;
      out_result_d = io.alu_result;
      out_opcode_d = head.opcode;
      out_zero_d   = (io.alu_result == '0);
      acc_d        = io.alu_result;
    end else if (out_valid_q && io.out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_opcode_q <= '0;
      out_zero_q   <= 1'b0;
      acc_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_opcode_q <= out_opcode_d;
      out_zero_q   <= out_zero_d;
      acc_q        <= acc_d;
    end
  end

  assign io.out_valid  = out_valid_q;
  assign io.out_result = out_result_q;
  assign io.out_opcode = out_opcode_q;
  assign io.out_zero   = out_zero_q;
  assign io.acc        = acc_q;
endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with a reference ALU and a result scoreboard.
module tb_alu_cmd_issue;
  import alu_pkg::*;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [N-1:0] res;
    logic [2:0]   op;
    logic         zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  alu_cmd_issue_if #(.N(N), .DEPTH(DEPTH)) io ();

  alu_cmd_issue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  always #5 clk = ~clk;

  // The ALU the stage drives.
  always_comb begin
    case (io.alu_opcode)
      OP_ADD:  io.alu_result = io.alu_a + io.alu_b;
      OP_SUB:  io.alu_result = io.alu_a - io.alu_b;
      OP_AND:  io.alu_result = io.alu_a & io.alu_b;
      OP_XOR:  io.alu_result = io.alu_a ^ io.alu_b;
      default: io.alu_result = ALU_DEFAULT_RESULT[N-1:0];
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next edge when valid&ready are seen here.
  always @(negedge clk) begin
    if (rst_n && io.out_valid && io.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", io.out_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_result", 32'(io.out_result), 32'(e.res));
        chk("out_opcode", 32'(io.out_opcode), 32'(e.op));
        chk("out_zero",   32'(io.out_zero),   32'(e.zero));
        chk("acc_vs_out", 32'(io.acc),        32'(e.res));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic ua, input logic [N-1:0] exp_res);
    bit ok = 0;
    int cyc = 0;
    io.in_valid   = 1'b1;
    io.in_opcode  = op;
    io.in_a       = a;
    io.in_b       = b;
    io.in_use_acc = ua;
    while (!ok && cyc < 50) begin
      @(negedge clk);
      ok = io.in_ready && rst_n;
      @(posedge clk);
      #1;
      cyc++;
    end
    io.in_valid = 1'b0;
    if (ok) sb.push_back('{res: exp_res, op: op, zero: (exp_res == '0)});
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance within 50 cycles");
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    io.in_valid   = 1'b0;
    io.in_opcode  = '0;
    io.in_a       = '0;
    io.in_b       = '0;
    io.in_use_acc = 1'b0;
    io.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_level",     32'(io.level),     32'd0);
    chk("rst_in_ready",  32'(io.in_ready),  32'd1);
    chk("rst_acc",       32'(io.acc),       32'd0);
    chk("rst_alu_a",     32'(io.alu_a),     32'd0);

    // Basic ADD and its one-cycle latency.
    send(OP_ADD, 8'h05, 8'h03, 1'b0, 8'h08);
    chk("lat_not_yet", 32'(io.out_valid), 32'd0);
    chk("lat_level",   32'(io.level),     32'd1);
    @(posedge clk); #1;
    chk("lat_valid",   32'(io.out_valid), 32'd1);
    chk("lat_acc",     32'(io.acc),       32'h08);
    drain();

    // Subtraction wrap and zero flag.
    send(OP_SUB, 8'h03, 8'h05, 1'b0, 8'hFE);
    send(OP_SUB, 8'h07, 8'h07, 1'b0, 8'h00);
    drain();

    // Back-to-back accumulator chain.
    send(OP_ADD, 8'h0A, 8'h05, 1'b0, 8'h0F);
    send(OP_ADD, 8'h55, 8'h01, 1'b1, 8'h10);
    send(OP_XOR, 8'h55, 8'hFF, 1'b1, 8'hEF);
    drain();
    @(posedge clk); #1;
    chk("chain_acc", 32'(io.acc), 32'hEF);

    // Backpressure: one result held, FIFO full.
    io.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(OP_ADD, N'(i), N'(i), 1'b0, N'(2 * i));
    @(posedge clk); #1;
    chk("bp_level",    32'(io.level),    32'd4);
    chk("bp_in_ready", 32'(io.in_ready), 32'd0);
    chk("bp_out_hold", 32'(io.out_result), 32'h02);
    chk("bp_alu_a",    32'(io.alu_a),    32'h02);
    io.out_ready = 1'b1;
    send(OP_ADD, 8'h06, 8'h06, 1'b0, 8'h0C);
    drain();

    // Undefined opcode passes through as all-ones.
    send(3'b101, 8'h12, 8'h34, 1'b0, 8'hFF);
    drain();
    @(posedge clk); #1;
    chk("op5_acc", 32'(io.acc), 32'hFF);

    // Reset mid-stream discards everything.
    io.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(OP_AND, 8'hF0, N'(8'h30 + i), 1'b0, 8'h30);
    chk("mid_valid", 32'(io.out_valid), 32'd1);
    chk("mid_level", 32'(io.level),     32'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    chk("rst2_out_valid",  32'(io.out_valid),  32'd0);
    chk("rst2_level",      32'(io.level),      32'd0);
    chk("rst2_in_ready",   32'(io.in_ready),   32'd1);
    chk("rst2_acc",        32'(io.acc),        32'd0);
    chk("rst2_out_result", 32'(io.out_result), 32'd0);
    io.out_ready = 1'b1;
    send(OP_ADD, 8'h01, 8'h02, 1'b0, 8'h03);
    drain();
    repeat (5) @(posedge clk);
    #1 chk("post_idle_valid", 32'(io.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
